gray_ptr_sync: RTL and testbench

- Gray-code pointer clock-domain crossing block.
- Flow: binary pointer from a foreign domain -> Gray encode -> multi-flop synchronizer in the local clock domain -> binary decode.
- Used by the async FIFO read/write controllers to bring the opposite-side address into their own domain for empty/full/level computation.
- Bundles the Gray encoder, the synchronizer chain and the Gray decoder in one block.

---
 rtl/gray_pkg.sv | 25 ++
 rtl/gray_sync_chain.sv | 22 ++
 rtl/gray_ptr_sync.sv | 44 ++++
 tb/tb_gray_ptr_sync.sv | 129 ++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Gray-code helpers shared by the pointer CDC blocks of the async FIFO.
// The functions work on a 32-bit word; callers zero-extend and truncate to their width.
package gray_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int GRAY_MAX_W      = 32;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  function automatic gray_word_t bin_to_gray(input gray_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero bits above the caller's width decode to zero, so truncation stays exact.
  function automatic gray_word_t gray_to_bin(input gray_word_t gray);
    gray_word_t bin;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_sync_chain.sv
// Multi-flop synchronizer: STAGES back-to-back async-reset registers, no logic in between.
module gray_sync_chain #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *)
  logic [STAGES-1:0][WIDTH-1:0] r_stage;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_stage <= '0;
    else       r_stage <= {r_stage[STAGES-2:0], i_d};
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// Brings a foreign-domain binary pointer into sys_clk_i: Gray encode, synchronize, decode.
module gray_ptr_sync
  import gray_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  sys_clk_i,
  input  logic                  sys_rst_i,
  input  logic [DATA_WIDTH-1:0] bin_i,
  output logic [DATA_WIDTH-1:0] gray_o,
  output logic [DATA_WIDTH-1:0] sync_gray_o,
  output logic [DATA_WIDTH-1:0] bin_o
);

  generate
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
      $error("gray_ptr_sync: SYNC_STAGES must be in 2..4");
    end
    if (DATA_WIDTH < 1 || DATA_WIDTH > GRAY_MAX_W) begin : g_bad_width
      $error("gray_ptr_sync: DATA_WIDTH must be in 1..32");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] w_gray;
  logic [DATA_WIDTH-1:0] w_sync;

  assign w_gray = DATA_WIDTH'(bin_to_gray(GRAY_MAX_W'(bin_i)));

  gray_sync_chain #(
    .WIDTH  (DATA_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk (sys_clk_i),
    .i_rst (sys_rst_i),
    .i_d   (w_gray),
    .o_q   (w_sync)
  );

  assign gray_o      = w_gray;
  assign sync_gray_o = w_sync;
  assign bin_o       = DATA_WIDTH'(gray_to_bin(GRAY_MAX_W'(w_sync)));

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Directed bench for gray_ptr_sync: default 8x2, a 4x3 variant and a 1-bit variant.
module tb_gray_ptr_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] bin8 = '0, gray8, sgray8, bout8;
  logic [3:0] bin4 = '0, gray4, sgray4, bout4;
  logic [0:0] bin1 = '0, gray1, sgray1, bout1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gray_ptr_sync #(.DATA_WIDTH(8), .SYNC_STAGES(2)) u_dut8 (
    .sys_clk_i(clk), .sys_rst_i(rst), .bin_i(bin8),
    .gray_o(gray8), .sync_gray_o(sgray8), .bin_o(bout8));

  gray_ptr_sync #(.DATA_WIDTH(4), .SYNC_STAGES(3)) u_dut4 (
    .sys_clk_i(clk), .sys_rst_i(rst), .bin_i(bin4),
    .gray_o(gray4), .sync_gray_o(sgray4), .bin_o(bout4));

  gray_ptr_sync #(.DATA_WIDTH(1), .SYNC_STAGES(2)) u_dut1 (
    .sys_clk_i(clk), .sys_rst_i(rst), .bin_i(bin1),
    .gray_o(gray1), .sync_gray_o(sgray1), .bin_o(bout1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed { logic [7:0] bin; logic [7:0] gray; } enc_vec_t;
  enc_vec_t enc_tbl [4] = '{'{8'h05, 8'h07}, '{8'h7F, 8'h40}, '{8'h80, 8'hC0}, '{8'hFF, 8'h80}};

  initial begin
    logic [7:0] exp_bin, exp_gray, prev_sgray;
    logic [0:0] hist1 [$];

    // power-up with reset held
    #1;
    chk("rst_sgray8", 32'(sgray8), 0);
    chk("rst_bout8",  32'(bout8),  0);
    chk("rst_bout4",  32'(bout4),  0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("pwrup_bout8", 32'(bout8), 0);

    // combinational encode table
    foreach (enc_tbl[i]) begin
      bin8 = enc_tbl[i].bin;
      #1;
      chk($sformatf("enc_%02h", enc_tbl[i].bin), 32'(gray8), 32'(enc_tbl[i].gray));
    end

    // flush back to zero, then latency of 0x2A
    @(negedge clk); bin8 = 8'h00;
    repeat (3) @(negedge clk);
    chk("flush_bout8", 32'(bout8), 0);
    bin8 = 8'h2A;
    @(posedge clk); #1;
    chk("lat_k_sgray", 32'(sgray8), 0);
    chk("lat_k_bout",  32'(bout8),  0);
    @(posedge clk); #1;
    chk("lat_k1_sgray", 32'(sgray8), 32'h3F);
    chk("lat_k1_bout",  32'(bout8),  32'h2A);

    // counting sweep with wrap; bench model is a 2-cycle delayed counter
    prev_sgray = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        exp_bin  = 8'(c - 2);
        exp_gray = exp_bin ^ (exp_bin >> 1);
        chk("sweep_bout",  32'(bout8),  32'(exp_bin));
        chk("sweep_sgray", 32'(sgray8), 32'(exp_gray));
        if (c >= 3) chk("sweep_1bit", $countones(sgray8 ^ prev_sgray), 1);
      end
      prev_sgray = sgray8;
      bin8 = 8'(c);
    end

    // async reset mid-stream
    @(negedge clk); bin8 = 8'h33;
    repeat (2) @(negedge clk);
    chk("pre_rst_bout", 32'(bout8), 32'h33);
    #2 rst = 1'b1;
    #1;
    chk("arst_sgray", 32'(sgray8), 0);
    chk("arst_bout",  32'(bout8),  0);
    bin8 = 8'h10;
    #1;
    chk("arst_gray_tracks", 32'(gray8), 32'h18);
    @(posedge clk); #1;
    chk("arst_hold_bout", 32'(bout8), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_e1_bout", 32'(bout8), 0);
    @(posedge clk); #1;
    chk("rel_e2_bout", 32'(bout8), 32'h10);

    // 4-bit, 3-stage variant
    @(negedge clk); bin4 = 4'h9;
    #1;
    chk("v4_gray", 32'(gray4), 32'hD);
    @(posedge clk); #1; chk("v4_e1_bout", 32'(bout4), 0);
    @(posedge clk); #1; chk("v4_e2_bout", 32'(bout4), 0);
    @(posedge clk); #1;
    chk("v4_e3_bout",  32'(bout4),  32'h9);
    chk("v4_e3_sgray", 32'(sgray4), 32'hD);

    // 1-bit variant: pseudo-random pattern, 2-cycle delay
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c >= 2) chk("v1_bout", 32'(bout1), 32'(hist1[c-2]));
      bin1 = 1'(((c * 5) >> 1) & 1);
      hist1.push_back(bin1);
      #1;
      chk("v1_gray", 32'(gray1), 32'(bin1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
